sram_bridge: RTL

- Data-memory bridge that sits directly downstream of the CPU core's load/store port.
- Converts one 32-bit word access into one or two 16-bit accesses on the external asynchronous SRAM: 20-bit half-word address, CE/UB/LB/WE/OE strobes, shared tri-state data bus.
- Runs a small FSM that sequences the low half first, then the high half.
- Reports completion with a one-cycle `ready` pulse and returns the assembled read word.

---
 rtl/sram_bridge.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sram_bridge.sv
// ---------------------------------------------------------------------------
// sram_bridge
//   Data-memory bridge between the CPU load/store port and an external
//   16-bit asynchronous SRAM.  One 32-bit word access is split into up to
//   two half-word SRAM cycles, low half first, each made of one SETUP cycle
//   followed by WAIT_CYCLES ACCESS cycles.  A half whose byte enables are
//   both zero is skipped, so a request with be=0 goes straight to DONE.
//
// Handshake: req_i is a one-cycle request pulse.  It is accepted only while
//   busy_o is low; a req_i seen while busy_o is high is dropped.  Every
//   accepted request produces exactly one ready_o pulse (state DONE), and
//   rdata_o is valid in that cycle and held until the next accepted request.
//   A reset between acceptance and ready_o cancels the access and no
//   ready_o pulse follows.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   req_i, we_i, addr_i,    request pulse, write flag, byte address
//   wdata_i, be_i           write data, byte enables (be_i[0] = bits 7:0)
//   rdata_o, ready_o,       assembled read word, completion pulse,
//   busy_o                  high whenever the FSM is not idle
//   sram_addr_o             half-word address {addr[20:2], half}
//   sram_dq_o/_i, _oe_o     data bus towards / from the pad, drive enable
//   sram_*_n_o              CE/OE/WE/UB/LB strobes, active low
//   dbg_state_o             current FSM state
// ---------------------------------------------------------------------------
module sram_bridge #(
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  be_i,
   output logic [31:0] rdata_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic [19:0] sram_addr_o,
   output logic [15:0] sram_dq_o,
   input  logic [15:0] sram_dq_i,
   output logic        sram_dq_oe_o,
   output logic        sram_ce_n_o,
   output logic        sram_oe_n_o,
   output logic        sram_we_n_o,
   output logic        sram_ub_n_o,
   output logic        sram_lb_n_o,
   output logic [2:0]  dbg_state_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LO_SETUP  = 3'd1;
   localparam logic [2:0] S_LO_ACCESS = 3'd2;
   localparam logic [2:0] S_HI_SETUP  = 3'd3;
   localparam logic [2:0] S_HI_ACCESS = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   logic [2:0]    state_q, state_d;
   logic          we_q, we_d;
   logic [18:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [19:0]   sram_addr_q, sram_addr_d;

   logic          last_access;
   logic          is_setup, is_access, is_active, hi_half;
   logic [1:0]    lane_pair;

   // Only the word-address bits reach the SRAM.
   logic          unused_addr;
   assign unused_addr = ^{addr_i[31:21], addr_i[1:0]};

   assign last_access = (cnt_q == CNT_LAST);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      sram_addr_d = sram_addr_q;
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               addr_d  = addr_i[20:2];
               wdata_d = wdata_i;
               be_d    = be_i;
               // A new read starts from zero so skipped lanes read back as 0.
               if (!we_i) rdata_d = '0;
               if (be_i[1:0] != 2'b00) begin
                  state_d     = S_LO_SETUP;
                  sram_addr_d = {addr_i[20:2], 1'b0};
               end else if (be_i[3:2] != 2'b00) begin
                  state_d     = S_HI_SETUP;
                  sram_addr_d = {addr_i[20:2], 1'b1};
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LO_SETUP: begin
            state_d = S_LO_ACCESS;
            cnt_d   = '0;
         end
         S_LO_ACCESS: begin
            if (last_access) begin
               if (!we_q) rdata_d[15:0] = sram_dq_i & {{8{be_q[1]}}, {8{be_q[0]}}};
               if (be_q[3:2] != 2'b00) begin
                  state_d     = S_HI_SETUP;
                  sram_addr_d = {addr_q, 1'b1};
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HI_SETUP: begin
            state_d = S_HI_ACCESS;
            cnt_d   = '0;
         end
         S_HI_ACCESS: begin
            if (last_access) begin
               if (!we_q) rdata_d[31:16] = sram_dq_i & {{8{be_q[3]}}, {8{be_q[2]}}};
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         sram_addr_q <= sram_addr_d;
      end
   end

   // Strobes are decoded from the state register alone, so an asynchronous
   // reset releases the SRAM bus in the same instant.  WE_n/OE_n are low only
   // in ACCESS states, which leaves an inactive SETUP cycle between halves.
   assign is_setup  = (state_q == S_LO_SETUP)  || (state_q == S_HI_SETUP);
   assign is_access = (state_q == S_LO_ACCESS) || (state_q == S_HI_ACCESS);
   assign is_active = is_setup || is_access;
   assign hi_half   = (state_q == S_HI_SETUP)  || (state_q == S_HI_ACCESS);
   assign lane_pair = hi_half ? be_q[3:2] : be_q[1:0];

   assign sram_ce_n_o  = ~is_active;
   assign sram_ub_n_o  = ~(is_active & lane_pair[1]);
   assign sram_lb_n_o  = ~(is_active & lane_pair[0]);
   assign sram_we_n_o  = ~(is_access & we_q);
   assign sram_oe_n_o  = ~(is_access & ~we_q);
   assign sram_dq_oe_o = is_active & we_q;
   assign sram_dq_o    = hi_half ? wdata_q[31:16] : wdata_q[15:0];
   assign sram_addr_o  = sram_addr_q;

   assign rdata_o     = rdata_q;
   assign ready_o     = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE);
   assign dbg_state_o = state_q;

endmodule
